// File: rtl/keccak_pkg.sv
// Shared Keccak definitions for the squeeze path: mode encodings, rates,
// fixed SHA3 digest lengths, FSM states and the lane endian switch.
package keccak_pkg;

    typedef enum logic [1:0] {
        MODE_SHAKE128 = 2'd0,
        MODE_SHAKE256 = 2'd1,
        MODE_SHA3_256 = 2'd2,
        MODE_SHA3_512 = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_STREAM    = 2'd1,
        ST_PERM_REQ  = 2'd2,
        ST_PERM_WAIT = 2'd3
    } state_e;

    localparam int RATE_MAX      = 1344;
    localparam int RATE_SHAKE128 = 1344;
    localparam int RATE_SHAKE256 = 1088;
    localparam int RATE_SHA3_256 = 1088;
    localparam int RATE_SHA3_512 = 576;

    localparam logic [31:0] LEN_SHA3_256 = 32'd32;
    localparam logic [31:0] LEN_SHA3_512 = 32'd64;

    function automatic int unsigned rate_bits(input mode_e m);
        case (m)
            MODE_SHAKE128: return RATE_SHAKE128;
            MODE_SHAKE256: return RATE_SHAKE256;
            MODE_SHA3_256: return RATE_SHA3_256;
            default:       return RATE_SHA3_512;
        endcase
    endfunction

    // Rate arrives top-aligned with stream byte 0 in the top byte; reversing
    // every byte puts stream byte j at bits [8j+7:8j] for any output width.
    function automatic logic [RATE_MAX-1:0] endian_switch(input logic [RATE_MAX-1:0] v);
        logic [RATE_MAX-1:0] r;
        r = '0;
        for (int j = 0; j < RATE_MAX / 8; j++)
            r[8*j +: 8] = v[RATE_MAX-1-8*j -: 8];
        return r;
    endfunction

endpackage

// File: rtl/piso_buffer.sv
// Parallel-in serial-out word buffer: loads a full block, presents the
// lowest word and shifts one word down per i_shift.
module piso_buffer #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 21
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_load,
    input  logic                     i_shift,
    input  logic [WIDTH*DEPTH-1:0]   i_data,
    output logic [WIDTH-1:0]         o_word
);

    logic [WIDTH*DEPTH-1:0] r_buf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_buf <= '0;
        else if (i_load)
            r_buf <= i_data;
        else if (i_shift)
            r_buf <= {{WIDTH{1'b0}}, r_buf[WIDTH*DEPTH-1:WIDTH]};
    end

    assign o_word = r_buf[WIDTH-1:0];

endmodule

// File: rtl/squeeze_unit.sv
// Keccak squeeze stage: streams rate blocks as W-bit words, requesting extra
// permutations as needed. Define SQUEEZE_KEEP_EN to add data_keep instead of zeroing tail bytes.
//
//  state        | meaning
//  ST_IDLE      | waiting for start
//  ST_STREAM    | presenting words of the current block
//  ST_PERM_REQ  | one-cycle perm_req pulse
//  ST_PERM_WAIT | waiting for perm_done to reload the buffer
module squeeze_unit
    import keccak_pkg::*;
#(
    parameter int W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          mode_in,
    input  logic [31:0]         out_bytes_in,
    input  logic [RATE_MAX-1:0] rate_in,
    output logic                perm_req,
    input  logic                perm_done,
    output logic [W-1:0]        data_out,
    output logic                data_valid,
    input  logic                data_ready,
    output logic                data_last,
`ifdef SQUEEZE_KEEP_EN
    output logic [W/8-1:0]      data_keep,
`endif
    output logic                busy,
    output logic                done
);

    generate
        if (W != 32 && W != 64) begin : g_bad_width
            $error("squeeze_unit: W must be 32 or 64");
        end
    endgenerate

    localparam int          WB    = W / 8;
    localparam int          BW    = $clog2(WB);
    localparam int          DEPTH = RATE_MAX / W;
    localparam logic [31:0] WB32  = 32'(WB);

    state_e       r_state;
    logic [31:0]  r_rem;
    logic [5:0]   r_wcnt;
    logic [5:0]   r_depth_m1;
    logic         r_valid;
    logic         r_perm_req;
    logic         r_done;
    logic         r_busy;

    logic [31:0]  w_len;
    logic [5:0]   w_depth_m1;
    logic         w_hs;
    logic         w_last_word;
    logic         w_load;
    logic [BW-1:0] w_tail;
    logic         w_partial;
    logic [WB-1:0] w_mask;
    logic [W-1:0] w_word;

    always_comb begin
        case (mode_e'(mode_in))
            MODE_SHA3_256: w_len = LEN_SHA3_256;
            MODE_SHA3_512: w_len = LEN_SHA3_512;
            default:       w_len = out_bytes_in;
        endcase
    end

    assign w_depth_m1  = 6'(rate_bits(mode_e'(mode_in)) / W - 1);
    assign w_hs        = r_valid & data_ready;
    assign w_last_word = (r_rem <= WB32);
    assign w_load      = (r_state == ST_IDLE && start && w_len != 32'd0) ||
                         (r_state == ST_PERM_WAIT && perm_done);
    assign w_tail      = r_rem[BW-1:0];
    assign w_partial   = w_last_word && (w_tail != '0);

    always_comb begin
        w_mask = '1;
        if (w_partial)
            for (int i = 0; i < WB; i++)
                if (i >= int'(w_tail))
                    w_mask[i] = 1'b0;
    end

    piso_buffer #(
        .WIDTH(W),
        .DEPTH(DEPTH)
    ) u_piso (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_shift(w_hs),
        .i_data (endian_switch(rate_in)),
        .o_word (w_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rem      <= '0;
            r_wcnt     <= '0;
            r_depth_m1 <= '0;
            r_valid    <= 1'b0;
            r_perm_req <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_perm_req <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_len == 32'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state    <= ST_STREAM;
                            r_rem      <= w_len;
                            r_wcnt     <= '0;
                            r_depth_m1 <= w_depth_m1;
                            r_valid    <= 1'b1;
                            r_busy     <= 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (w_hs) begin
                        // Last word wins over end-of-block: no permutation after the final word.
                        r_rem  <= w_last_word ? '0 : r_rem - WB32;
                        r_wcnt <= r_wcnt + 6'd1;
                        if (w_last_word) begin
                            r_state <= ST_IDLE;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (r_wcnt == r_depth_m1) begin
                            r_state    <= ST_PERM_REQ;
                            r_valid    <= 1'b0;
                            r_perm_req <= 1'b1;
                        end
                    end
                end
                ST_PERM_REQ: begin
                    r_state <= ST_PERM_WAIT;
                end
                ST_PERM_WAIT: begin
                    if (perm_done) begin
                        r_state <= ST_STREAM;
                        r_wcnt  <= '0;
                        r_valid <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef SQUEEZE_KEEP_EN
    assign data_out  = r_valid ? w_word : '0;
    assign data_keep = r_valid ? w_mask : '0;
`else
    always_comb begin
        data_out = '0;
        if (r_valid)
            for (int i = 0; i < WB; i++)
                data_out[8*i +: 8] = w_mask[i] ? w_word[8*i +: 8] : 8'h00;
    end
`endif

    assign data_valid = r_valid;
    assign data_last  = r_valid & w_last_word;
    assign perm_req   = r_perm_req;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
